vlc_frame_parser: RTL and testbench

Downstream consumer of the 8-bit bit-accumulator stage. Takes its byte plus one-cycle byte strobe, hunts for a sync byte, and parses the frame as SYNC, LEN, LEN payload bytes, CHK. Payload is stored in an internal frame buffer and released to the link/host side over a valid/ready stream only after the checksum passes; bad, oversized or stalled frames are discarded.

---
 rtl/vlc_frame_parser.sv | 233 +++++++++++++++++++++++
 tb/tb_vlc_frame_parser.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vlc_frame_parser.sv
// Frame parser: hunts SYNC, reads LEN, buffers payload, verifies CHK (sum of LEN and payload,
// mod 256), then drains the frame over a valid/ready stream. Optional stats: VLC_FRAME_STATS_EN.
module vlc_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
`ifdef VLC_FRAME_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
`endif
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic [7:0]      out_byte_q, out_byte_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            frame_ok_q, frame_ok_d;
  logic            frame_err_q, frame_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            busy_q, busy_d;

  logic [7:0]      buf_mem [MAX_LEN];
  logic            buf_we;
  logic [PW-1:0]   rd_nxt;

  assign rd_nxt = rd_ptr_q + PW'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    idle_d      = idle_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    busy_d      = busy_q;
    buf_we      = 1'b0;

    case (state_q)
      S_HUNT: begin
        if (in_valid && in_byte == SYNC_BYTE) begin
          state_d = S_LEN;
          idle_d  = '0;
        end
      end
      S_LEN: begin
        if (in_valid) begin
          idle_d = '0;
          if (in_byte == 8'd0 || in_byte > 8'(MAX_LEN)) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd0;
            state_d     = S_HUNT;
          end else begin
            len_d    = in_byte;
            sum_d    = in_byte;
            wr_ptr_d = '0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (in_valid) begin
          idle_d   = '0;
          buf_we   = 1'b1;
          sum_d    = sum_q + in_byte;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (8'(wr_ptr_q) == len_q - 8'd1) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (in_valid) begin
          idle_d = '0;
          if (in_byte == sum_q) begin
            frame_ok_d  = 1'b1;
            out_valid_d = 1'b1;
            out_byte_d  = buf_mem[0];
            out_last_d  = (len_q == 8'd1);
            busy_d      = 1'b1;
            rd_ptr_d    = '0;
            state_d     = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = S_HUNT;
          end
        end
      end
      S_DRAIN: begin
        // Input cannot be back-pressured, so a strobe here is a lost byte.
        if (in_valid) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
        end
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            state_d     = S_HUNT;
          end else begin
            rd_ptr_d   = rd_nxt;
            out_byte_d = buf_mem[rd_nxt];
            out_last_d = (8'(rd_nxt) == len_q - 8'd1);
          end
        end
      end
      default: state_d = S_HUNT;
    endcase

    // Inter-byte idle watchdog, active only while a frame is open.
    if ((state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHECK) && !in_valid) begin
      if (idle_q == IDLE_LAST) begin
        frame_err_d = 1'b1;
        err_code_d  = 2'd2;
        idle_d      = '0;
        state_d     = S_HUNT;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HUNT;
      len_q       <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idle_q      <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idle_q      <= idle_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: the frame buffer is not reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_ptr_q] <= in_byte;
  end

  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

`ifdef VLC_FRAME_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (frame_ok_q && good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
    if (frame_err_q && bad_cnt_q != 16'hFFFF) bad_cnt_d = bad_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign good_cnt = good_cnt_q;
  assign bad_cnt  = bad_cnt_q;
`else
  // Statistics counters are absent in the default build.
`endif

endmodule

// File: tb/tb_vlc_frame_parser.sv
// Directed self-checking bench for vlc_frame_parser (SYNC=A5, MAX_LEN=32, TIMEOUT=1023).
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_vlc_frame_parser;

  logic       clk;
  logic       rst;
  logic [7:0] in_byte;
  logic       in_valid;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
`ifdef VLC_FRAME_STATS_EN
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
`endif

  int total = 0;
  int bad   = 0;

  vlc_frame_parser dut (
    .clk       (clk),
    .rst       (rst),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
`ifdef VLC_FRAME_STATS_EN
    ,
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] data [32];
    logic [7:0] chk;
    int idx;

    rst = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // Checksum covers LEN too, so 66 alone is wrong: 03+11+22+33 = 69.
    out_ready = 1'b1;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h66);
    check("nolen_chk_err", frame_err, 1);
    check("nolen_chk_code", err_code, 1);
    check("nolen_chk_valid", out_valid, 0);
    tick();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    check("pre_chk_valid", out_valid, 0);
    send(8'h69);
    check("f1_ok", frame_ok, 1);
    check("f1_err", frame_err, 0);
    check("f1_valid0", out_valid, 1);
    check("f1_byte0", out_byte, 8'h11);
    check("f1_last0", out_last, 0);
    check("f1_busy", busy, 1);
    tick();
    check("f1_ok_pulse", frame_ok, 0);
    check("f1_byte1", out_byte, 8'h22);
    check("f1_last1", out_last, 0);
    tick();
    check("f1_byte2", out_byte, 8'h33);
    check("f1_last2", out_last, 1);
    tick();
    check("f1_done_valid", out_valid, 0);
    check("f1_done_busy", busy, 0);

    // Bad checksum, then a valid single-byte frame: 01+7F = 80.
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
    check("f2_err", frame_err, 1);
    check("f2_code", err_code, 1);
    check("f2_valid", out_valid, 0);
    tick();
    check("f2_err_pulse", frame_err, 0);
    send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
    check("f3_ok", frame_ok, 1);
    check("f3_byte", out_byte, 8'h7F);
    check("f3_last", out_last, 1);
    tick();
    check("f3_done_valid", out_valid, 0);

    // LEN out of range at both ends.
    send(8'hA5); send(8'h00);
    check("len0_err", frame_err, 1);
    check("len0_code", err_code, 0);
    tick();
    check("len0_pulse", frame_err, 0);
    send(8'hA5); send(8'd33);
    check("len33_err", frame_err, 1);
    check("len33_code", err_code, 0);
    tick();

    // Idle watchdog: abort lands exactly TIMEOUT cycles after the last accepted byte.
    send(8'hA5); send(8'h04); send(8'h01);
    repeat (1022) tick();
    check("tmo_early", frame_err, 0);
    tick();
    check("tmo_err", frame_err, 1);
    check("tmo_code", err_code, 2);
    tick();
    send(8'hA5); send(8'h01); send(8'h05); send(8'h06);
    check("f4_ok", frame_ok, 1);
    check("f4_byte", out_byte, 8'h05);
    check("f4_last", out_last, 1);
    tick();
    check("f4_done_valid", out_valid, 0);

    // Full-size frame with a SYNC value inside the payload, drained under stalls.
    out_ready = 1'b0;
    chk = 8'd32;
    for (int i = 0; i < 32; i++) begin
      data[i] = 8'(i * 3 + 32);
      if (i == 5) data[i] = 8'hA5;
      chk = chk + data[i];
    end
    send(8'hA5); send(8'd32);
    for (int i = 0; i < 32; i++) send(data[i]);
    send(chk);
    check("f5_ok", frame_ok, 1);
    idx = 0;
    for (int c = 0; c < 80 && idx < 32; c++) begin
      check("f5_valid", out_valid, 1);
      check("f5_byte", out_byte, data[idx]);
      check("f5_last", out_last, (idx == 31) ? 1 : 0);
      check("f5_busy", busy, 1);
      out_ready = (c % 2 == 1);
      if (c == 4) begin
        in_byte  = 8'hA5;
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      if (c == 4) begin
        check("lost_err", frame_err, 1);
        check("lost_code", err_code, 3);
        check("lost_busy", busy, 1);
      end
      if (c == 5) check("lost_pulse", frame_err, 0);
      if (out_ready) idx++;
    end
    check("f5_count", idx, 32);
    check("f5_done_valid", out_valid, 0);
    check("f5_done_busy", busy, 0);

    // Reset in the middle of a payload, then resync through leading junk.
    out_ready = 1'b1;
    send(8'hA5); send(8'h04); send(8'h11); send(8'h22);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_err_code", err_code, 0);
    check("mid_rst_out_byte", out_byte, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", frame_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(8'h00);
    check("junk_no_err", frame_err, 0);
    send(8'hA5); send(8'h02); send(8'h0A); send(8'h0B); send(8'h17);
    check("f6_ok", frame_ok, 1);
    check("f6_byte0", out_byte, 8'h0A);
    check("f6_last0", out_last, 0);
    tick();
    check("f6_byte1", out_byte, 8'h0B);
    check("f6_last1", out_last, 1);
    tick();
    check("f6_done_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
